// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Carry-in occupies prefix position -1 (vector index 0); bit i sits at index i+1.
// A single global enable advances every stage at once, so a stalled output
// freezes the whole pipe, bubbles included.
module prefix_adder_pipe #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned LVL_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned LAT    = (LEVELS + LVL_PER_STAGE - 1) / LVL_PER_STAGE + 1;
  // Stage registers ahead of the output register: the input stage plus one per
  // prefix group except the last, whose result lands in the output register.
  localparam int unsigned NG     = LAT - 1;
  localparam int unsigned N      = WIDTH + 1;

  localparam logic [1:0] KpgK = 2'b00;
  localparam logic [1:0] KpgP = 2'b01;
  localparam logic [1:0] KpgG = 2'b10;

  // One Kogge-Stone level: a propagate takes the value found span positions lower.
  function automatic logic [2*N-1:0] ks_level(input logic [2*N-1:0] v, input int unsigned span);
    logic [2*N-1:0] r;
    r = v;
    for (int unsigned i = 0; i < N; i++) begin
      if (i >= span && v[2*i +: 2] == KpgP) begin
        r[2*i +: 2] = v[2*(i-span) +: 2];
      end
    end
    return r;
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [2*N-1:0]   kpg_in;

  logic [NG-1:0]    vld_q;
  logic [WIDTH-1:0] a_q    [NG];
  logic [WIDTH-1:0] be_q   [NG];
  logic [2*N-1:0]   kpg_q  [NG];

  logic [2*N-1:0]   lvl_in  [LEVELS];
  logic [2*N-1:0]   lvl_out [LEVELS];

  logic [2*N-1:0]   pre;
  logic [1:0]       top;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  assign en        = out_ready || !out_valid_q;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Operand conditioning and per-position kill/propagate/generate.
  always_comb begin
    b_eff        = sub ? ~b : b;
    c_eff        = sub | cin;
    kpg_in       = '0;
    kpg_in[1:0]  = c_eff ? KpgG : KpgK;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] & b_eff[i]) begin
        kpg_in[2*(i+1) +: 2] = KpgG;
      end else if (a[i] ^ b_eff[i]) begin
        kpg_in[2*(i+1) +: 2] = KpgP;
      end else begin
        kpg_in[2*(i+1) +: 2] = KpgK;
      end
    end
  end

  // Prefix levels; a group starts from a stage register, later levels chain combinationally.
  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    if (j % LVL_PER_STAGE == 0) begin : g_from_reg
      assign lvl_in[j] = kpg_q[j / LVL_PER_STAGE];
    end else begin : g_from_comb
      assign lvl_in[j] = lvl_out[j-1];
    end
    assign lvl_out[j] = ks_level(lvl_in[j], 2**j);
  end

  // Stage registers: operands and kpg at the input, prefix state at each group boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < NG; s++) begin
        a_q[s]   <= '0;
        be_q[s]  <= '0;
        kpg_q[s] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      be_q[0]  <= b_eff;
      kpg_q[0] <= kpg_in;
      for (int s = 1; s < NG; s++) begin
        vld_q[s] <= vld_q[s-1];
        a_q[s]   <= a_q[s-1];
        be_q[s]  <= be_q[s-1];
        kpg_q[s] <= lvl_out[s*LVL_PER_STAGE-1];
      end
    end
  end

  // Carries, sum and flags from the completed prefix.
  always_comb begin
    pre = lvl_out[LEVELS-1];
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = (pre[2*i +: 2] == KpgG);
    end
    sum_d  = a_q[NG-1] ^ be_q[NG-1] ^ carry;
    // Top span stops just short of position -1; an all-propagate word passes the carry-in.
    top    = pre[2*WIDTH +: 2];
    cout_d = (top == KpgG) || (top == KpgP && pre[1:0] == KpgG);
    ovf_d  = (a_q[NG-1][WIDTH-1] == be_q[NG-1][WIDTH-1]) &&
             (sum_d[WIDTH-1] != a_q[NG-1][WIDTH-1]);
    zero_d = (sum_d == '0);
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (en) begin
      out_valid_q <= vld_q[NG-1];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed bench for prefix_adder_pipe: a 32-bit single-level-per-stage instance
// and an 8-bit two-levels-per-stage instance.
module tb_prefix_adder_pipe;

  localparam int LAT32 = 6;
  localparam int LAT8  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;

  prefix_adder_pipe #(.WIDTH(32), .LVL_PER_STAGE(1)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  prefix_adder_pipe #(.WIDTH(8), .LVL_PER_STAGE(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
    .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    bit          narrow;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue one operation, measure edges from acceptance to out_valid, compare result.
  task automatic run_vec(input vec_t v, input string tag);
    int          n;
    logic [31:0] rs;
    logic        rco, rov, rz;
    @(negedge clk);
    if (v.narrow) begin
      a8 = v.a[7:0]; b8 = v.b[7:0]; cin8 = v.cin; sub8 = v.sub; in_valid8 = 1'b1;
    end else begin
      a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    n = 0;
    while (!(v.narrow ? out_valid8 : out_valid) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (v.narrow) begin
      rs = {24'h0, sum8}; rco = cout8; rov = ovf8; rz = zero8;
    end else begin
      rs = sum; rco = cout; rov = ovf; rz = zero;
    end
    check($sformatf("%s.latency", tag), n, v.narrow ? LAT8 - 1 : LAT32 - 1);
    check($sformatf("%s.sum", tag), rs, v.s);
    check($sformatf("%s.cout", tag), rco, v.co);
    check($sformatf("%s.ovf", tag), rov, v.ov);
    check($sformatf("%s.zero", tag), rz, v.z);
  endtask

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          idx, got, extra, stale;
  logic        acc, held_v;
  logic [31:0] held_s;

  initial begin
    //              a             b             cin   sub   sum           co    ov    z     narrow
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00000007, 32'h00000007, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h00000080, 32'h00000080, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{32'h0000007F, 32'h00000001, 1'b0, 1'b0, 32'h00000080, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h000000FF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'h000000FE, 1'b0, 1'b0, 1'b0, 1'b1});

    rst = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

    // Reset state, applied between clock edges.
    #2 rst = 1'b1;
    #1;
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.sum", sum, 32'h0);
    check("reset.flags", {cout, ovf, zero}, 3'b000);
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.out_valid8", out_valid8, 1'b0);
    check("reset.in_ready8", in_ready8, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset.in_ready", in_ready, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Ten back-to-back ops with a three-cycle consumer stall.
    idx = 0; got = 0; extra = 0; held_v = 1'b0; held_s = '0;
    sub = 1'b0; cin = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 8 && cyc <= 10);
      if (idx < 10) begin
        in_valid = 1'b1;
        a = 32'h00010000 * idx + 32'h7;
        b = 32'h00FFFFF0 + idx;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        check("stream.hold_valid", out_valid, 1'b1);
        check("stream.hold_sum", sum, held_s);
      end
      if (cyc >= 8 && cyc <= 10) check("stream.stall_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) extra++;
        else begin
          check($sformatf("stream.sum%0d", got), sum, exp_q.pop_front());
          got++;
        end
      end
      held_v = out_valid && !out_ready;
      held_s = sum;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(a + b);
        idx++;
      end
    end
    check("stream.count", got, 10);
    check("stream.extra", extra, 0);
    out_ready = 1'b1;

    // Reset with operations in flight.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'h100 + i; b = 32'h1; cin = 1'b0; sub = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("flight.pre_valid", out_valid, 1'b1);
    check("flight.pre_sum", sum, 32'h101);
    #1 rst = 1'b1;
    #1;
    check("flight.rst_valid", out_valid, 1'b0);
    check("flight.rst_sum", sum, 32'h0);
    check("flight.rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("flight.stale", stale, 0);
    run_vec('{32'h00000010, 32'h00000020, 1'b1, 1'b0, 32'h00000031, 1'b0, 1'b0, 1'b0, 1'b0},
            "flight.next");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
